// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, opcode and ALU function encodings shared by control_fsm_mc.
package ctrl_pkg;

    localparam int OPC_W_DEF = 6;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'b100000;
    localparam logic [5:0] OPC_ADDI  = 6'b110000;
    localparam logic [5:0] OPC_ANDI  = 6'b110010;
    localparam logic [5:0] OPC_ORI   = 6'b110011;
    localparam logic [5:0] OPC_B     = 6'b111111;
    localparam logic [5:0] OPC_BEQ   = 6'b000000;
    localparam logic [5:0] OPC_BNE   = 6'b000001;
    localparam logic [5:0] OPC_LB    = 6'b000011;
    localparam logic [5:0] OPC_LW    = 6'b001111;
    localparam logic [5:0] OPC_SB    = 6'b000111;
    localparam logic [5:0] OPC_SW    = 6'b011111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

endpackage

// File: rtl/ctrl_opc_decode.sv
// ctrl_opc_decode: combinational opcode classifier for control_fsm_mc.
module ctrl_opc_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W = OPC_W_DEF
) (
    input  logic [OPC_W-1:0] opc,
    output logic             valid,
    output logic             is_branch,
    output logic             is_load,
    output logic             is_store,
    output logic             is_imm,
    output logic             is_byte,
    output logic [3:0]       imm_alu_func
);

    function automatic logic is_op(input logic [OPC_W-1:0] o, input logic [5:0] c);
        return o == OPC_W'(c);
    endfunction

    always_comb begin
        is_imm       = is_op(opc, OPC_ADDI) || is_op(opc, OPC_ANDI) || is_op(opc, OPC_ORI);
        is_branch    = is_op(opc, OPC_B) || is_op(opc, OPC_BEQ) || is_op(opc, OPC_BNE);
        is_load      = is_op(opc, OPC_LB) || is_op(opc, OPC_LW);
        is_store     = is_op(opc, OPC_SB) || is_op(opc, OPC_SW);
        is_byte      = is_op(opc, OPC_LB) || is_op(opc, OPC_SB);
        valid        = is_imm || is_branch || is_load || is_store || is_op(opc, OPC_RTYPE);
        imm_alu_func = is_op(opc, OPC_ANDI) ? ALU_AND : is_op(opc, OPC_ORI) ? ALU_OR : ALU_ADD;
    end

endmodule

// File: rtl/control_fsm_mc.sv
// control_fsm_mc: multi-cycle control FSM with MEM handshake timeout and illegal-opcode trap.
// Optional CTRL_PERF_CNT_EN adds Retired_cnt / Stall_cnt performance counters.
module control_fsm_mc
    import ctrl_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int OPC_W      = OPC_W_DEF,
    parameter int ALU_FUNC_W = 4,
    parameter int MEM_TMO    = 15
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [INSTR_W-1:0]    Instr,
    input  logic                  ALU_zero,
    input  logic                  MEM_ready,
    output logic                  IR_LdEn,
    output logic                  PC_LdEn,
    output logic                  PC_sel,
    output logic                  RF_B_sel,
    output logic                  RF_WrData_sel,
    output logic                  RF_WrEn,
    output logic                  ALU_Bin_sel,
    output logic [ALU_FUNC_W-1:0] ALU_func,
    output logic                  MEM_req,
    output logic                  MEM_we,
    output logic                  MEM_In_sel,
    output logic                  Illegal,
    output logic [2:0]            State
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]           Retired_cnt,
    output logic [31:0]           Stall_cnt
`endif
);

    state_t                state_q, state_d;
    logic [OPC_W-1:0]      opc_q, opc_d;
    logic [ALU_FUNC_W-1:0] func_q, func_d;
    logic [7:0]            tmo_q, tmo_d;
    logic                  dec_valid, is_branch, is_load, is_store, is_imm, is_byte;
    logic [3:0]            imm_func;
    logic                  in_exec, in_mem, in_wb, stall, tmo_hit, br_taken;
    logic                  unused_instr;

    assign unused_instr = ^Instr[INSTR_W-OPC_W-1:ALU_FUNC_W];

    // In DECODE the classifier looks at the live IR so the EXEC/TRAP choice is made this cycle.
    always_comb begin
        opc_d  = state_q == S_DECODE ? Instr[INSTR_W-1 -: OPC_W] : opc_q;
        func_d = state_q == S_DECODE ? Instr[ALU_FUNC_W-1:0] : func_q;
    end

    ctrl_opc_decode #(
        .OPC_W(OPC_W)
    ) u_dec (
        .opc         (opc_d),
        .valid       (dec_valid),
        .is_branch   (is_branch),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_imm      (is_imm),
        .is_byte     (is_byte),
        .imm_alu_func(imm_func)
    );

    always_comb begin
        in_exec  = state_q == S_EXEC;
        in_mem   = state_q == S_MEM;
        in_wb    = state_q == S_WB;
        stall    = in_mem && !MEM_ready;
        tmo_hit  = stall && tmo_q == 8'(MEM_TMO - 1);
        tmo_d    = stall && !tmo_hit ? tmo_q + 8'd1 : 8'd0;
        br_taken = opc_q == OPC_W'(OPC_B) || (opc_q == OPC_W'(OPC_BEQ) && ALU_zero) ||
                   (opc_q == OPC_W'(OPC_BNE) && !ALU_zero);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            opc_q   <= '0;
            func_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            func_q  <= func_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = dec_valid ? S_EXEC : S_TRAP;
            S_EXEC:   state_d = is_branch ? S_FETCH : (is_load || is_store) ? S_MEM : S_WB;
            S_MEM:    state_d = MEM_ready ? (is_load ? S_WB : S_FETCH) : tmo_hit ? S_TRAP : S_MEM;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        IR_LdEn       = Reset && state_q == S_FETCH;
        PC_LdEn       = (in_exec && is_branch) || (in_mem && is_store && MEM_ready) || in_wb;
        PC_sel        = in_exec && is_branch && br_taken;
        RF_B_sel      = in_exec && is_branch;
        RF_WrData_sel = in_wb && is_load;
        RF_WrEn       = in_wb;
        ALU_Bin_sel   = in_exec && (is_imm || is_load || is_store);
        ALU_func      = !in_exec ? '0 :
                        is_branch ? ALU_FUNC_W'(ALU_SUB) :
                        is_imm ? ALU_FUNC_W'(imm_func) :
                        (is_load || is_store) ? ALU_FUNC_W'(ALU_ADD) : func_q;
        MEM_req       = in_mem;
        MEM_we        = in_mem && is_store;
        MEM_In_sel    = in_mem && is_byte;
        Illegal       = state_q == S_TRAP;
        State         = state_q;
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_q, retired_d, stall_q, stall_d;

    always_comb begin
        retired_d = retired_q + 32'(PC_LdEn);
        stall_d   = stall_q + 32'(stall);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign Retired_cnt = retired_q;
    assign Stall_cnt   = stall_q;
`endif

endmodule

// File: doc/control_fsm_mc.md
Name: control_fsm_mc

Overview:
Parametrised multi-cycle control unit for the single-issue datapath; successor to the fixed 32-bit CONTROL FSM. Adds configurable instruction/function widths, a memory request/ready handshake with timeout, and an illegal-opcode trap state. Sits between the instruction register and the PC/RF/ALU/MEM datapath muxes.

Parameters:
INSTR_W, 32, instruction width; opcode is Instr[INSTR_W-1 -: OPC_W]
OPC_W, 6, opcode field width
ALU_FUNC_W, 4, ALU_func width; R-type func is Instr[ALU_FUNC_W-1:0]
MEM_TMO, 15, max MEM wait cycles before trap (1..255)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Instr  in  INSTR_W  current instruction from IR
ALU_zero  in  1  ALU zero flag, valid in EXEC
MEM_ready  in  1  memory access complete
IR_LdEn  out  1  load IR
PC_LdEn  out  1  load PC
PC_sel  out  1  1 = branch target, 0 = PC+4
RF_B_sel  out  1  RF read port B from rd field
RF_WrData_sel  out  1  1 = memory data, 0 = ALU result
RF_WrEn  out  1  register file write
ALU_Bin_sel  out  1  1 = immediate, 0 = RF B
ALU_func  out  ALU_FUNC_W  ALU operation
MEM_req  out  1  memory access request
MEM_we  out  1  memory write
MEM_In_sel  out  1  1 = byte, 0 = word
Illegal  out  1  sticky trap flag
State  out  3  current state (debug)

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Outputs are Moore, decoded from state plus opcode register.
- Reset low (any time, incl. mid-instruction or in TRAP): state=FETCH, opcode/func regs=0, timeout counter=0, all outputs 0.
- FETCH: IR_LdEn=1 -> DECODE.
- DECODE: capture opcode and func into regs; these stay held until next DECODE. Opcode valid -> EXEC, else -> TRAP.
- Opcodes: 100000 R-type (ALU_func=func); 110000 addi (0000); 110010 andi (0010); 110011 ori (0011); 111111 b; 000000 beq; 000001 bne; 000011 lb; 001111 lw; 000111 sb; 011111 sw.
- EXEC: ALU_Bin_sel=1 for immediate, load and store ops. Branches use ALU_func=0001 (sub) and RF_B_sel=1.
- Branch in EXEC: PC_LdEn=1 -> FETCH. PC_sel=1 for b; for beq when ALU_zero=1; for bne when ALU_zero=0.
- EXEC routing: ALU ops -> WB; loads/stores -> MEM.
- Load/store address add: ALU_func=0000.
- MEM: MEM_req=1; MEM_we=1 for stores; MEM_In_sel=1 for lb/sb. Timeout counter increments each cycle MEM_ready=0.
  - MEM_ready=1 -> load goes to WB; store asserts PC_LdEn this cycle -> FETCH.
  - Counter reaching MEM_TMO with MEM_ready=0 -> TRAP. MEM_ready=1 on the MEM_TMO cycle wins.
  - Counter clears on leaving MEM.
- WB: RF_WrEn=1; RF_WrData_sel=1 for loads; PC_LdEn=1 -> FETCH.
- TRAP: Illegal=1, all other outputs 0. Held until reset.
- Latency with zero wait: branch 3 cycles; ALU 4; store 4; load 5. Each wait cycle adds 1.
- PC_LdEn is exactly one pulse per retired instruction. It is never asserted in FETCH, DECODE or TRAP.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined: adds 32-bit outputs Retired_cnt (+1 on each PC_LdEn) and Stall_cnt (+1 per MEM cycle with MEM_ready=0). Both are cleared by reset and wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package ctrl_pkg holds: state encodings, opcode constants, ALU_func codes (ADD=0000, SUB=0001, AND=0010, OR=0011), OPC_W default.
- One sub-module, ctrl_opc_decode: combinational opcode -> {valid, is_branch, is_load, is_store, is_imm, is_byte, imm_alu_func}.
- FSM, timeout counter and optional perf counters stay in the top module.

Test Plan:
- Reset low mid-EXEC -> State=0 and all outputs 0 immediately; release -> FETCH with IR_LdEn=1 on the next cycle.
- beq (opcode 000000), ALU_zero=1 -> PC_LdEn=PC_sel=1 in cycle 3. Same with ALU_zero=0 -> PC_sel=0. bne gives the inverse.
- R-type 0x80000003 -> ALU_func=0011 in EXEC; RF_WrEn=1 and PC_LdEn=1 in cycle 4.
- lw (0x3C000000), MEM_ready low 2 cycles -> MEM_req high 3 cycles; WB in cycle 7 with RF_WrData_sel=1. With CTRL_PERF_CNT_EN: Stall_cnt=2, Retired_cnt=1.
- sb (0x1C000000) -> MEM_we=1, MEM_In_sel=1, PC_LdEn with MEM_ready. MEM_ready held low with MEM_TMO=15 -> TRAP after 15 MEM cycles, Illegal=1.
- Opcode 101010 -> DECODE -> TRAP; Illegal stays 1 and PC_LdEn stays 0 for 20 cycles; cleared only by reset.
